// File: rtl/mem_wb.sv
// mem_wb: MEM -> WB pipeline register.
// Formats load data (big-endian byte/halfword lanes, sign/zero extension),
// registers the register-file write port, honours stall/flush, and counts
// committed register writes.
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_ld_type,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_rdata,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_cnt
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;

  // Select the addressed lane of a big-endian word and extend it to 32 bits.
  // Non-load codes pass the ALU/move result through unchanged.
  function automatic logic [31:0] fmt_load(
    input logic [2:0]  ld_type,
    input logic [1:0]  addr_lo,
    input logic [31:0] rdata,
    input logic [31:0] wdata
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr_lo)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      2'd3:    byte_v = rdata[7:0];
      default: byte_v = 8'd0;
    endcase
    // Halfword lane is chosen by addr_lo[1] alone; addr_lo[0] is ignored.
    if (addr_lo[1]) begin
      half_v = rdata[15:0];
    end else begin
      half_v = rdata[31:16];
    end
    case (ld_type)
      LD_LB:   res_v = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  res_v = {24'd0, byte_v};
      LD_LH:   res_v = {{16{half_v[15]}}, half_v};
      LD_LHU:  res_v = {16'd0, half_v};
      LD_LW:   res_v = rdata;
      default: res_v = wdata;
    endcase
    return res_v;
  endfunction

  logic        cap_valid_s;
  logic [31:0] fmt_data_s;
  logic        nxt_we_s;
  logic [4:0]  nxt_waddr_s;
  logic [31:0] nxt_wdata_s;

  // Next write-port value: flush beats stall; a write to r0 or a non-write
  // becomes a full bubble so r0 never appears with we high.
  always_comb begin
    nxt_we_s    = wb_we;
    nxt_waddr_s = wb_waddr;
    nxt_wdata_s = wb_wdata;
    fmt_data_s  = fmt_load(mem_ld_type, mem_addr_lo, mem_rdata, mem_wdata);
    cap_valid_s = mem_we && (mem_waddr != 5'd0);
    if (flush) begin
      nxt_we_s    = 1'b0;
      nxt_waddr_s = 5'd0;
      nxt_wdata_s = 32'd0;
    end else if (stall[4] && !stall[5]) begin
      nxt_we_s    = 1'b0;
      nxt_waddr_s = 5'd0;
      nxt_wdata_s = 32'd0;
    end else if (stall[4]) begin
      nxt_we_s    = wb_we;
      nxt_waddr_s = wb_waddr;
      nxt_wdata_s = wb_wdata;
    end else if (cap_valid_s) begin
      nxt_we_s    = 1'b1;
      nxt_waddr_s = mem_waddr;
      nxt_wdata_s = fmt_data_s;
    end else begin
      nxt_we_s    = 1'b0;
      nxt_waddr_s = 5'd0;
      nxt_wdata_s = 32'd0;
    end
  end

  // Write-port register and committed-write counter (counts every cycle the
  // registered we is high, including held cycles; wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'd0;
      wb_cnt   <= 32'd0;
    end else begin
      wb_we    <= nxt_we_s;
      wb_waddr <= nxt_waddr_s;
      wb_wdata <= nxt_wdata_s;
      if (wb_we) begin
        wb_cnt <= wb_cnt + 32'd1;
      end else begin
        wb_cnt <= wb_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: table-driven self-checking bench for mem_wb with a scoreboard
// queue of expected write-port/counter values.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic [5:0]  stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_cnt;

  mem_wb dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_ld_type(mem_ld_type), .mem_addr_lo(mem_addr_lo),
    .mem_rdata(mem_rdata), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  ld;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [5:0]  stall;
    logic        flush;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        prev_we = 1'b0;
  vec_t  tbl[$];

  localparam logic [31:0] RD = 32'h80F17F02;

  function automatic vec_t mk(string n, logic r, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [2:0] ld, logic [1:0] lo, logic [5:0] st, logic fl,
                              logic ewe, logic [4:0] ewa, logic [31:0] ewd);
    vec_t v;
    v.name = n; v.rst = r; v.we = we; v.waddr = wa; v.wdata = wd; v.ld = ld; v.lo = lo;
    v.rdata = RD; v.stall = st; v.flush = fl; v.e_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, then pop and
  // compare just after the capturing rising edge.
  task automatic apply(vec_t v);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = v.rst; mem_we = v.we; mem_waddr = v.waddr; mem_wdata = v.wdata;
    mem_ld_type = v.ld; mem_addr_lo = v.lo; mem_rdata = v.rdata;
    stall = v.stall; flush = v.flush;
    if (v.rst) begin
      exp_cnt = 32'd0;
      prev_we = 1'b0;
    end else begin
      if (prev_we) exp_cnt = exp_cnt + 32'd1;
      prev_we = v.e_we;
    end
    e.name = v.name; e.we = v.rst ? 1'b0 : v.e_we; e.waddr = v.rst ? 5'd0 : v.e_waddr;
    e.wdata = v.rst ? 32'd0 : v.e_wdata; e.cnt = exp_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      g = sb_q.pop_front();
      chk({g.name, ".we"},    {31'd0, wb_we},    {31'd0, g.we});
      chk({g.name, ".waddr"}, {27'd0, wb_waddr}, {27'd0, g.waddr});
      chk({g.name, ".wdata"}, wb_wdata,          g.wdata);
      chk({g.name, ".cnt"},   wb_cnt,            g.cnt);
    end
  endtask

  initial begin
    rst = 1'b1; mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0; mem_ld_type = 3'd0;
    mem_addr_lo = 2'd0; mem_rdata = 32'd0; stall = 6'd0; flush = 1'b0;

    // name rst we wa wdata ld lo stall flush | e_we e_wa e_wdata
    tbl.push_back(mk("rst0",   1, 1, 5'd5, 32'h12345678, 3'd0, 2'd0, 6'b000000, 0, 0, 5'd0, 32'd0));
    tbl.push_back(mk("rst1",   1, 1, 5'd5, 32'h12345678, 3'd0, 2'd0, 6'b000000, 0, 0, 5'd0, 32'd0));
    tbl.push_back(mk("alu",    0, 1, 5'd5, 32'h12345678, 3'd0, 2'd0, 6'b000000, 0, 1, 5'd5, 32'h12345678));
    tbl.push_back(mk("lb0",    0, 1, 5'd1, 32'h0,        3'd1, 2'd0, 6'b000000, 0, 1, 5'd1, 32'hFFFFFF80));
    tbl.push_back(mk("lbu1",   0, 1, 5'd2, 32'h0,        3'd2, 2'd1, 6'b000000, 0, 1, 5'd2, 32'h000000F1));
    tbl.push_back(mk("lh2",    0, 1, 5'd3, 32'h0,        3'd3, 2'd2, 6'b000000, 0, 1, 5'd3, 32'h00007F02));
    tbl.push_back(mk("lh0",    0, 1, 5'd4, 32'h0,        3'd3, 2'd0, 6'b000000, 0, 1, 5'd4, 32'hFFFF80F1));
    tbl.push_back(mk("lhu1",   0, 1, 5'd6, 32'h0,        3'd4, 2'd1, 6'b000000, 0, 1, 5'd6, 32'h000080F1));
    tbl.push_back(mk("lw3",    0, 1, 5'd8, 32'h0,        3'd5, 2'd3, 6'b000000, 0, 1, 5'd8, 32'h80F17F02));
    tbl.push_back(mk("lb3",    0, 1, 5'd9, 32'h0,        3'd1, 2'd3, 6'b000000, 0, 1, 5'd9, 32'h00000002));
    tbl.push_back(mk("lbu2",   0, 1, 5'd10, 32'h0,       3'd2, 2'd2, 6'b000000, 0, 1, 5'd10, 32'h0000007F));
    tbl.push_back(mk("lh3",    0, 1, 5'd11, 32'h0,       3'd3, 2'd3, 6'b000000, 0, 1, 5'd11, 32'h00007F02));
    tbl.push_back(mk("lhu0",   0, 1, 5'd12, 32'h0,       3'd4, 2'd0, 6'b000000, 0, 1, 5'd12, 32'h000080F1));
    tbl.push_back(mk("ld6",    0, 1, 5'd13, 32'hCAFE0006, 3'd6, 2'd1, 6'b001111, 0, 1, 5'd13, 32'hCAFE0006));
    tbl.push_back(mk("r0",     0, 1, 5'd0, 32'hDEADBEEF, 3'd0, 2'd0, 6'b000000, 0, 0, 5'd0, 32'd0));
    tbl.push_back(mk("nowe",   0, 0, 5'd9, 32'h55555555, 3'd0, 2'd0, 6'b000000, 0, 0, 5'd0, 32'd0));
    tbl.push_back(mk("r7",     0, 1, 5'd7, 32'hA5A50007, 3'd0, 2'd0, 6'b000000, 0, 1, 5'd7, 32'hA5A50007));
    tbl.push_back(mk("hold1",  0, 1, 5'd2, 32'h11111111, 3'd0, 2'd0, 6'b110000, 0, 1, 5'd7, 32'hA5A50007));
    tbl.push_back(mk("hold2",  0, 0, 5'd3, 32'h22222222, 3'd5, 2'd0, 6'b110000, 0, 1, 5'd7, 32'hA5A50007));
    tbl.push_back(mk("hold3",  0, 1, 5'd0, 32'h33333333, 3'd0, 2'd0, 6'b110000, 0, 1, 5'd7, 32'hA5A50007));
    tbl.push_back(mk("mstall", 0, 1, 5'd4, 32'h44444444, 3'd0, 2'd0, 6'b010000, 0, 0, 5'd0, 32'd0));
    tbl.push_back(mk("wbonly", 0, 1, 5'd3, 32'h00000011, 3'd0, 2'd0, 6'b100000, 0, 1, 5'd3, 32'h00000011));
    tbl.push_back(mk("flsh_st",0, 1, 5'd5, 32'h66666666, 3'd0, 2'd0, 6'b110000, 1, 0, 5'd0, 32'd0));
    tbl.push_back(mk("flsh",   0, 1, 5'd6, 32'h77777777, 3'd0, 2'd0, 6'b000000, 1, 0, 5'd0, 32'd0));
    // Reset in the middle of a hold: held write is dropped, counter cleared.
    tbl.push_back(mk("r9",     0, 1, 5'd9, 32'h99999999, 3'd0, 2'd0, 6'b000000, 0, 1, 5'd9, 32'h99999999));
    tbl.push_back(mk("hold9",  0, 0, 5'd0, 32'h0,        3'd0, 2'd0, 6'b110000, 0, 1, 5'd9, 32'h99999999));
    tbl.push_back(mk("rsthold",1, 1, 5'd9, 32'h0,        3'd0, 2'd0, 6'b110000, 0, 0, 5'd0, 32'd0));
    tbl.push_back(mk("afterrst",0, 0, 5'd0, 32'h0,       3'd0, 2'd0, 6'b110000, 0, 0, 5'd0, 32'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Counter wrap: preload the counter to all ones while no write is pending.
    @(negedge clk);
    force dut.wb_cnt = 32'hFFFFFFFF;
    #1;
    release dut.wb_cnt;
    exp_cnt = 32'hFFFFFFFF;
    apply(mk("wrapw",  0, 1, 5'd1, 32'h00000001, 3'd0, 2'd0, 6'b000000, 0, 1, 5'd1, 32'h00000001));
    apply(mk("wrap0",  0, 0, 5'd0, 32'h0,        3'd0, 2'd0, 6'b000000, 0, 0, 5'd0, 32'd0));
    apply(mk("wrap1",  0, 0, 5'd0, 32'h0,        3'd0, 2'd0, 6'b000000, 0, 0, 5'd0, 32'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register between the memory-access stage and the register file's write port. Captures the memory-stage result each cycle, formats load data (byte/halfword select, sign/zero extension, big-endian lanes), and drives the register file's `we`/`waddr`/`wdata`. Honours the pipeline stall vector and flush, and keeps a 32-bit count of committed register writes.

## Interface
- `LD_LB`, 3'd1, load type: byte, sign-extended
- `LD_LBU`, 3'd2, load type: byte, zero-extended
- `LD_LH`, 3'd3, load type: halfword, sign-extended
- `LD_LHU`, 3'd4, load type: halfword, zero-extended
- `LD_LW`, 3'd5, load type: word; any other code = not a load (pass `mem_wdata`)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous and active-high
- `mem_we` in 1: memory-stage instruction writes a register
- `mem_waddr` in 5: destination register
- `mem_wdata` in 32: ALU/move result (used when not a load)
- `mem_ld_type` in 3: load type code above
- `mem_addr_lo` in 2: low two bits of the load effective address
- `mem_rdata` in 32: raw word returned by data memory this cycle
- `stall` in 6: pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
- `flush` in 1: discard the instruction being captured
- `wb_we` out 1: register-file write enable
- `wb_waddr` out 5: register-file write address
- `wb_wdata` out 32: register-file write data
- `wb_cnt` out 32: committed-write counter

## Operation
- Load formatting happens before capture. Byte lanes are big-endian: `addr_lo`=0 selects bits 31:24, 1 selects 23:16, 2 selects 15:8, 3 selects 7:0.
  - Halfword loads use `addr_lo[1]` only: 0 selects 31:16, 1 selects 15:0. `addr_lo[0]` is ignored.
  - LW ignores `addr_lo`.
- Capture rules, evaluated in priority order on each edge:
  1. `rst`=1: `wb_we`=0, `wb_waddr`=0, `wb_wdata`=0, `wb_cnt`=0.
  2. `flush`=1: bubble (`wb_we`=0, `wb_waddr`=0, `wb_wdata`=0).
  3. `stall[4]`=1 and `stall[5]`=0: bubble.
  4. `stall[4]`=1 and `stall[5]`=1: hold all three write outputs.
  5. `stall[4]`=0: capture `mem_we`, `mem_waddr` and the formatted data.
- A capture with `mem_we`=0 or `mem_waddr`=0 registers as a bubble: all three write outputs become 0.
  - Reason: the register file forwards `wdata` to any read port whose address equals `waddr` while `we` is high, including register 0. Register 0 must never appear with `we`=1.
- `wb_cnt` increments by 1 on every edge where the registered `wb_we` is 1 (including held cycles under stall) and `rst`=0. It wraps from 0xFFFFFFFF to 0. It is not affected by `flush`.

## Timing
- Latency: 1 cycle. Values captured at edge N are driven from edge N until the next capture, bubble, or reset.
- The register file writes at the edge after `wb_we` rises, and its read ports see `wb_wdata` combinationally in the same cycle. No extra forwarding is required from this block.
- `mem_rdata` must be valid in the cycle of capture. Multi-cycle memory is handled upstream by asserting `stall[4]`.
- `wb_cnt` reflects writes retired up to and including the previous cycle.
- Reset mid-stall or mid-hold clears everything at that edge. The held instruction is lost and not counted after reset.
- Simultaneous `flush` and `stall[4]`/`stall[5]`: flush wins.

## Test plan
- **Reset**: hold `rst`=1 for 2 cycles with `mem_we`=1, `mem_waddr`=5 → all outputs 0. Release `rst`, capture `mem_wdata`=0x12345678 → next cycle `wb_we`=1, `wb_waddr`=5, `wb_wdata`=0x12345678, `wb_cnt`=0. The cycle after that, `wb_cnt`=1.
- **Load formatting**: `mem_rdata`=0x80F17F02.
  - LB at `addr_lo`=0 → 0xFFFFFF80.
  - LBU at `addr_lo`=1 → 0x000000F1.
  - LH at `addr_lo`=2 → 0x00007F02.
  - LH at `addr_lo`=0 → 0xFFFF80F1.
  - LHU at `addr_lo`=1 → 0x000080F1.
  - LW at `addr_lo`=3 → 0x80F17F02.
- **Register 0**: `mem_we`=1, `mem_waddr`=0, `mem_wdata`=0xDEADBEEF → `wb_we`=0, `wb_wdata`=0, and `wb_cnt` does not increment.
- **Stall**:
  - Capture a write to r7. Then set `stall`=6'b110000 for 3 cycles → outputs hold r7/data, and `wb_cnt` increases by 3 beyond the first count.
  - Then `stall`=6'b010000 for 1 cycle → bubble.
- **Flush**: `flush`=1 with `stall`=6'b110000 and a valid `mem_we`=1 → bubble next cycle. `wb_cnt` keeps its value.
- **Counter wrap**: preload `wb_cnt` to 0xFFFFFFFF via 2^32−1 writes, or force it in simulation. One more write → `wb_cnt`=0.
